// File: rtl/spi_pkg.sv
// Shared types and register map for the APB-hosted SPI master.
package spi_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_state_e;

   localparam logic [2:0] CR_OFS  = 3'd0;
   localparam logic [2:0] SR_OFS  = 3'd1;
   localparam logic [2:0] TXD_OFS = 3'd2;
   localparam logic [2:0] RXD_OFS = 3'd3;
   localparam logic [2:0] DIV_OFS = 3'd4;

   localparam int CR_CS    = 0;
   localparam int CR_CPOL  = 1;
   localparam int CR_CPHA  = 2;
   localparam int CR_START = 3;

   localparam int SR_BUSY  = 0;
   localparam int SR_DONE  = 1;
endpackage

// File: rtl/spi_master_core.sv
// SPI master engine: SCLK divider, edge counter and shift registers.
// state | meaning
// IDLE  | sclk parked at the configured CPOL, waiting for start
// SHIFT | running 2*DATA_W SCLK edges
// DONE  | one cycle; received byte is handed to the register file
module spi_master_core
   import spi_pkg::*;
#(
   parameter int DIV_W  = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              start_cpol,
   input  logic              start_cpha,
   input  logic [DIV_W-1:0]  start_div,
   input  logic [DATA_W-1:0] start_tx,
   input  logic              idle_cpol,
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data
);
   localparam int EW = $clog2(2 * DATA_W);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

   spi_state_e        state;
   logic              cpol_q;
   logic              cpha_q;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_cnt;
   logic [EW-1:0]     edge_cnt;
   logic [DATA_W-1:0] tx_sh;
   logic [DATA_W-1:0] rx_sh;
   logic              tick;
   logic              leading;
   logic              shift_out;
   logic              sample;

   // Even edge count means the next toggle leaves the idle level.
   assign tick      = (div_cnt == div_q);
   assign leading   = ~edge_cnt[0];
   assign shift_out = tick & (leading == cpha_q) & (edge_cnt != LAST_EDGE);
   assign sample    = tick & (leading != cpha_q);

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign rx_data = rx_sh;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         div_q    <= '0;
         div_cnt  <= '0;
         edge_cnt <= '0;
         tx_sh    <= '0;
         rx_sh    <= '0;
      end else begin
         case (state)
            IDLE: begin
               sclk <= idle_cpol;
               if (start) begin
                  state    <= SHIFT;
                  cpol_q   <= start_cpol;
                  cpha_q   <= start_cpha;
                  div_q    <= start_div;
                  div_cnt  <= '0;
                  edge_cnt <= '0;
                  sclk     <= start_cpol;
                  // CPHA=0 must have the MSB on the wire before the first edge.
                  if (!start_cpha) begin
                     mosi  <= start_tx[DATA_W-1];
                     tx_sh <= start_tx << 1;
                  end else begin
                     tx_sh <= start_tx;
                  end
               end
            end
            SHIFT: begin
               if (tick) begin
                  div_cnt  <= '0;
                  sclk     <= ~sclk;
                  edge_cnt <= edge_cnt + 1'b1;
                  if (shift_out) begin
                     mosi  <= tx_sh[DATA_W-1];
                     tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                  end
                  if (sample) begin
                     rx_sh <= {rx_sh[DATA_W-2:0], miso};
                  end
                  if (edge_cnt == LAST_EDGE) begin
                     state <= DONE;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               sclk  <= cpol_q;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/apb_spi_master_periph.sv
// APB responder with one wait state: register file, read mux and SPI engine.
module apb_spi_master_periph
   import spi_pkg::*;
#(
   parameter int DIV_W  = 8,
   parameter int DATA_W = 8
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   input  logic        PWRITE,
   input  logic        PENABLE,
   input  logic        PSEL,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   output logic        cs_n
);
   logic              access;
   logic              wr_en;
   logic              rd_en;
   logic [2:0]        ofs;
   logic              cr_cs;
   logic              cr_cpol;
   logic              cr_cpha;
   logic [DATA_W-1:0] txd;
   logic [DATA_W-1:0] rxd;
   logic [DIV_W-1:0]  clkdiv;
   logic              done_flag;
   logic              core_busy;
   logic              core_done;
   logic [DATA_W-1:0] core_rx;
   logic              start;
   logic              done_clr;
   logic [31:0]       rdata_mux;
   logic              unused_bits;

   assign ofs    = PADDR[4:2];
   assign access = PSEL & PENABLE & ~PREADY;
   assign wr_en  = access & PWRITE;
   assign rd_en  = access & ~PWRITE;
   assign start  = wr_en & (ofs == CR_OFS) & PWDATA[CR_START] & ~core_busy;
   assign done_clr = (wr_en & (ofs == SR_OFS) & PWDATA[SR_DONE]) |
                     (rd_en & (ofs == RXD_OFS));
   assign cs_n   = ~cr_cs;
   assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:8]};

   always_comb begin
      rdata_mux = '0;
      case (ofs)
         CR_OFS: begin
            rdata_mux[CR_CS]   = cr_cs;
            rdata_mux[CR_CPOL] = cr_cpol;
            rdata_mux[CR_CPHA] = cr_cpha;
         end
         SR_OFS: begin
            rdata_mux[SR_BUSY] = core_busy;
            rdata_mux[SR_DONE] = done_flag;
         end
         TXD_OFS: rdata_mux[DATA_W-1:0] = txd;
         RXD_OFS: rdata_mux[DATA_W-1:0] = rxd;
         DIV_OFS: rdata_mux[DIV_W-1:0]  = clkdiv;
         default: rdata_mux = '0;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PREADY    <= 1'b0;
         PRDATA    <= '0;
         cr_cs     <= 1'b0;
         cr_cpol   <= 1'b0;
         cr_cpha   <= 1'b0;
         txd       <= '0;
         rxd       <= '0;
         clkdiv    <= '0;
         done_flag <= 1'b0;
      end else begin
         PREADY <= 1'b0;
         if (access) begin
            PREADY <= 1'b1;
            PRDATA <= rdata_mux;
         end
         if (wr_en) begin
            case (ofs)
               CR_OFS: begin
                  cr_cs   <= PWDATA[CR_CS];
                  cr_cpol <= PWDATA[CR_CPOL];
                  cr_cpha <= PWDATA[CR_CPHA];
               end
               TXD_OFS: txd    <= PWDATA[DATA_W-1:0];
               DIV_OFS: clkdiv <= PWDATA[DIV_W-1:0];
               default: ;
            endcase
         end
         // Completion beats a same-cycle clear; the read still sees the old RXD.
         if (core_done) begin
            done_flag <= 1'b1;
            rxd       <= core_rx;
         end else if (done_clr) begin
            done_flag <= 1'b0;
         end
      end
   end

   spi_master_core #(
      .DIV_W  (DIV_W),
      .DATA_W (DATA_W)
   ) u_core (
      .clk        (PCLK),
      .rst        (PRESET),
      .start      (start),
      .start_cpol (PWDATA[CR_CPOL]),
      .start_cpha (PWDATA[CR_CPHA]),
      .start_div  (clkdiv),
      .start_tx   (txd),
      .idle_cpol  (cr_cpol),
      .miso       (miso),
      .sclk       (sclk),
      .mosi       (mosi),
      .busy       (core_busy),
      .done       (core_done),
      .rx_data    (core_rx)
   );
endmodule

// File: tb/tb_apb_spi_master_periph.sv
// Bench for apb_spi_master_periph: register vectors, SPI slave model, timing corners.
module tb_apb_spi_master_periph;
   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic [31:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic        PWRITE = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PSEL = 1'b0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic        cs_n;

   always #5 PCLK = ~PCLK;

   apb_spi_master_periph dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PWRITE  (PWRITE),
      .PENABLE (PENABLE),
      .PSEL    (PSEL),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .sclk    (sclk),
      .mosi    (mosi),
      .miso    (miso),
      .cs_n    (cs_n)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // SPI slave model: acts on SCLK levels relative to its configured mode.
   bit         sl_on = 1'b0;
   bit         sl_cpol = 1'b0;
   bit         sl_cpha = 1'b0;
   bit         lb = 1'b0;
   logic [7:0] sl_tx = '0;
   logic [7:0] sl_rx = '0;
   logic [2:0] sl_bit = 3'd7;

   assign miso = lb ? mosi : sl_tx[sl_bit];

   always @(sclk) begin
      if (sl_on) begin
         if ((sclk != sl_cpol) == !sl_cpha) sl_rx = {sl_rx[6:0], mosi};
         else sl_bit = sl_bit - 3'd1;
      end
   end

   // Line monitor sampled on the falling PCLK edge.
   int   mon_edges = 0;
   int   mon_since = 0;
   int   mon_gap_exp = 1;
   int   mon_gap_bad = 0;
   int   mon_mosi_bad = 0;
   bit   mon_on = 1'b0;
   logic prev_sclk = 1'b0;
   logic prev_mosi = 1'b0;

   always @(negedge PCLK) begin
      mon_since++;
      if (sclk !== prev_sclk) begin
         if (mon_edges > 0 && mon_since != mon_gap_exp) mon_gap_bad++;
         mon_edges++;
         mon_since = 0;
      end
      if (mon_on && mosi !== prev_mosi && !(prev_sclk === 1'b1 && sclk === 1'b0))
         mon_mosi_bad++;
      prev_sclk = sclk;
      prev_mosi = mosi;
   end

   task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd);
      int n;
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
      @(negedge PCLK);
      PENABLE = 1'b1;
      n = 0;
      do begin
         @(negedge PCLK);
         n++;
      end while (!PREADY && n < 8);
      if (!PREADY) begin
         total++; bad++;
         $display("FAIL apb_timeout: addr 0x%0h got no PREADY", addr);
      end
      rd = PRDATA;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic apb_wr(input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] d;
      apb(1'b1, addr, wd, d);
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      apb(1'b0, addr, 32'h0, d);
      chk(nm, d, exp);
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      do begin
         @(posedge PCLK); #1;
         cyc++;
      end while (dut.u_core.busy && cyc < 3000);
      if (cyc >= 3000) begin
         total++; bad++;
         $display("FAIL busy_timeout: still busy after %0d cycles", cyc);
      end
   endtask

   task automatic arm(input bit cpol, input bit cpha, input logic [7:0] sb, input int div);
      sl_cpol = cpol; sl_cpha = cpha; sl_tx = sb; sl_rx = '0;
      sl_bit = cpha ? 3'd0 : 3'd7;
      sl_on = 1'b1;
      mon_edges = 0; mon_gap_bad = 0; mon_gap_exp = div + 1; mon_mosi_bad = 0;
   endtask

   // Reference expectations: slave sees TX, RXD gets slave byte (or TX in loopback),
   // 16 SCLK edges spaced CLKDIV+1 apart, busy for 16*(CLKDIV+1)+1 cycles.
   task automatic run_xfer(input bit cpol, input bit cpha, input logic [7:0] div,
                           input logic [7:0] tx, input logic [7:0] sb, input bit lb_i,
                           input bit wr_tx, input bit mon_mosi);
      int cyc;
      logic [31:0] mode;
      mode = {29'd0, cpha, cpol, 1'b1};
      apb_wr(32'h10, {24'd0, div});
      if (wr_tx) apb_wr(32'h08, {24'd0, tx});
      apb_wr(32'h00, mode);
      repeat (2) @(negedge PCLK);
      chk("idle_sclk_pre", sclk, cpol);
      chk("cs_active", cs_n, 0);
      lb = lb_i;
      arm(cpol, cpha, sb, int'(div));
      mon_on = mon_mosi;
      apb_wr(32'h00, mode | 32'h8);
      wait_idle(cyc);
      chk("duration", cyc, 16 * (int'(div) + 1) + 1);
      chk("sclk_edges", mon_edges, 16);
      chk("sclk_gap_bad", mon_gap_bad, 0);
      if (!lb_i) chk("slave_rx", sl_rx, tx);
      if (mon_mosi) chk("mosi_off_edge", mon_mosi_bad, 0);
      chk("idle_sclk_post", sclk, cpol);
      sl_on = 1'b0; mon_on = 1'b0; lb = 1'b0;
      rd_chk("sr_done", 32'h04, 32'h2);
      rd_chk("rxd", 32'h0C, lb_i ? {24'd0, tx} : {24'd0, sb});
      rd_chk("sr_cleared", 32'h04, 32'h0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          chk_rd;
      logic [31:0] exp_rd;
      bit          exp_csn;
      bit          exp_sclk;
   } vec_t;

   function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] wd, bit c,
                               logic [31:0] e, bit csn, bit sc);
      vec_t v;
      v.wr = wr; v.addr = a; v.wd = wd; v.chk_rd = c; v.exp_rd = e;
      v.exp_csn = csn; v.exp_sclk = sc;
      return v;
   endfunction

   initial begin
      vec_t vecs[$];
      logic [31:0] d;
      int cyc;
      int n;

      // Reset
      repeat (3) @(negedge PCLK);
      chk("rst_pready", PREADY, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      PRESET = 1'b0;

      vecs.push_back(mk(0, 32'h04, 0, 1, 32'h0, 1, 0));
      vecs.push_back(mk(0, 32'h0C, 0, 1, 32'h0, 1, 0));
      vecs.push_back(mk(0, 32'h1C, 0, 1, 32'h0, 1, 0));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'h0, 1, 0));
      vecs.push_back(mk(1, 32'h08, 32'h1A5, 0, 0, 1, 0));
      vecs.push_back(mk(0, 32'h08, 0, 1, 32'hA5, 1, 0));
      vecs.push_back(mk(1, 32'h00, 32'h7, 0, 0, 0, 1));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'h7, 0, 1));
      vecs.push_back(mk(1, 32'h14, 32'hFF, 0, 0, 0, 1));
      vecs.push_back(mk(0, 32'h14, 0, 1, 32'h0, 0, 1));
      vecs.push_back(mk(1, 32'h10, 32'hFFFF_FF5A, 0, 0, 0, 1));
      vecs.push_back(mk(0, 32'h10, 0, 1, 32'h5A, 0, 1));
      vecs.push_back(mk(1, 32'h04, 32'h3, 0, 0, 0, 1));
      vecs.push_back(mk(0, 32'h04, 0, 1, 32'h0, 0, 1));
      vecs.push_back(mk(1, 32'h00, 32'h0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 32'h00, 0, 1, 32'h0, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         apb(vecs[i].wr, vecs[i].addr, vecs[i].wd, d);
         if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
         repeat (2) @(negedge PCLK);
         chk($sformatf("vec%0d_cs_n", i), cs_n, vecs[i].exp_csn);
         chk($sformatf("vec%0d_sclk", i), sclk, vecs[i].exp_sclk);
      end

      // APB wait-state timing with the access held past PREADY
      @(negedge PCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h3;
      @(negedge PCLK);
      chk("pready_setup", PREADY, 0);
      PENABLE = 1'b1;
      @(negedge PCLK);
      chk("pready_access", PREADY, 1);
      @(negedge PCLK);
      chk("pready_not_twice", PREADY, 0);
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      chk("pready_idle", PREADY, 0);
      rd_chk("clkdiv_rb", 32'h10, 32'h3);

      // Mode 0 loopback, then mode 3 against the slave
      run_xfer(1'b0, 1'b0, 8'd1, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0);
      run_xfer(1'b1, 1'b1, 8'd0, 8'hC3, 8'h3C, 1'b0, 1'b1, 1'b1);

      // Start and TXD write while busy
      apb_wr(32'h10, 32'h1);
      apb_wr(32'h08, 32'h5A);
      apb_wr(32'h00, 32'h1);
      repeat (2) @(negedge PCLK);
      arm(1'b0, 1'b0, 8'h96, 1);
      apb_wr(32'h00, 32'h9);
      repeat (4) @(negedge PCLK);
      apb_wr(32'h08, 32'hFF);
      apb_wr(32'h00, 32'h9);
      wait_idle(cyc);
      chk("busy_edges", mon_edges, 16);
      chk("busy_slave_rx", sl_rx, 32'h5A);
      sl_on = 1'b0;
      rd_chk("busy_sr", 32'h04, 32'h2);
      repeat (40) @(negedge PCLK);
      chk("no_restart_edges", mon_edges, 16);
      rd_chk("no_restart_sr", 32'h04, 32'h2);
      rd_chk("busy_rxd", 32'h0C, 32'h96);
      rd_chk("busy_txd", 32'h08, 32'hFF);
      run_xfer(1'b0, 1'b0, 8'd1, 8'hFF, 8'h69, 1'b0, 1'b0, 1'b0);

      // Randomised transfers
      for (int i = 0; i < 6; i++) begin
         bit cp, ch;
         logic [7:0] dv, tx, sb;
         cp = 1'($urandom_range(0, 1));
         ch = 1'($urandom_range(0, 1));
         dv = 8'($urandom_range(0, 3));
         tx = 8'($urandom);
         sb = 8'($urandom);
         run_xfer(cp, ch, dv, tx, sb, 1'b0, 1'b1, 1'b0);
      end

      // SR W1C landing on the completion edge (start edge + 33)
      apb_wr(32'h10, 32'h1);
      apb_wr(32'h08, 32'h33);
      apb_wr(32'h00, 32'h1);
      repeat (2) @(negedge PCLK);
      lb = 1'b1;
      apb_wr(32'h00, 32'h9);
      repeat (30) @(negedge PCLK);
      apb_wr(32'h04, 32'h2);
      wait_idle(cyc);
      lb = 1'b0;
      rd_chk("w1c_race_sr", 32'h04, 32'h2);
      rd_chk("w1c_race_rxd", 32'h0C, 32'h33);
      rd_chk("w1c_race_clr", 32'h04, 32'h0);

      // RXD read on the completion edge returns the previous byte
      apb_wr(32'h08, 32'h4C);
      lb = 1'b1;
      apb_wr(32'h00, 32'h9);
      repeat (30) @(negedge PCLK);
      apb(1'b0, 32'h0C, 32'h0, d);
      chk("rxd_race_old", d, 32'h33);
      wait_idle(cyc);
      lb = 1'b0;
      rd_chk("rxd_race_sr", 32'h04, 32'h2);
      rd_chk("rxd_race_new", 32'h0C, 32'h4C);
      rd_chk("rxd_race_clr", 32'h04, 32'h0);

      // Reset at the 7th SCLK edge of a CPOL=1 transfer
      apb_wr(32'h08, 32'h81);
      apb_wr(32'h00, 32'h3);
      repeat (2) @(negedge PCLK);
      mon_edges = 0;
      apb_wr(32'h00, 32'hB);
      n = 0;
      while (mon_edges < 7 && n < 200) begin
         @(negedge PCLK);
         n++;
      end
      chk("edge7_reached", mon_edges, 7);
      PRESET = 1'b1;
      repeat (2) @(negedge PCLK);
      PRESET = 1'b0;
      chk("abort_sclk", sclk, 0);
      chk("abort_cs_n", cs_n, 1);
      chk("abort_mosi", mosi, 0);
      rd_chk("abort_sr", 32'h04, 32'h0);
      rd_chk("abort_rxd", 32'h0C, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/apb_spi_master_periph.md
Name: apb_spi_master_periph

Overview:
- APB responder peripheral hosting an 8-bit SPI master engine. It is the slave-side counterpart of the MCU's APB initiator.
- Attaches to one PSEL/PRDATA/PREADY slot of the APB master decoder, with the same port style as the GPIO/UART/timer peripherals.
- Firmware programs divider, mode and TX byte, then starts a transfer; software polls status and reads the received byte.

Parameters:
- DIV_W, 8, width of the SCLK divider register.
- DATA_W, 8, bits per SPI transfer.

Ports:
- PCLK  input  1  system clock; all logic is on its rising edge.
- PRESET  input  1  synchronous, active-high reset.
- PADDR  input  32  APB address; only PADDR[4:2] is decoded.
- PWDATA  input  32  APB write data.
- PWRITE  input  1  1 = write, 0 = read.
- PENABLE  input  1  APB access phase.
- PSEL  input  1  slave select.
- PRDATA  output  32  read data, registered.
- PREADY  output  1  transfer complete, registered.
- sclk  output  1  SPI clock.
- mosi  output  1  SPI data out, MSB first.
- miso  input  1  SPI data in.
- cs_n  output  1  chip select, active low, software-controlled.

Behaviour:
- Reset values: PRDATA=0, PREADY=0, sclk=0, mosi=0, cs_n=1, all registers 0, FSM=IDLE. Reset mid-transfer aborts immediately, with no done flag.
- APB timing (one wait state):
  - When PSEL&&PENABLE&&!PREADY, the next edge sets PREADY=1, performs the register write, and loads PRDATA. The following edge clears PREADY.
  - PREADY is never high two consecutive cycles.
  - With PSEL low, PREADY=0 and PRDATA holds its value.
- Register map (word offsets):
  - 0x00 CR: [0] cs (cs_n=~cs), [1] CPOL, [2] CPHA, [3] start. start is write-only, self-clearing and reads 0.
  - 0x04 SR: [0] busy (read-only), [1] done (sticky, write-1-to-clear).
  - 0x08 TXD: [7:0].
  - 0x0C RXD: [7:0], read-only. Reading RXD clears done.
  - 0x10 CLKDIV: [DIV_W-1:0]. SCLK half-period = CLKDIV+1 PCLK cycles.
  - Unmapped offsets read 0; writes to them are ignored.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE→SHIFT: on a CR write with start=1 while not busy. Latches CPOL, CPHA, CLKDIV and TXD into a shift register; busy=1.
  - CPHA=0: mosi presents the MSB in the cycle after start.
  - SHIFT: a half-period counter counts 0..CLKDIV. On wrap, sclk toggles and the edge counter increments.
    - Leading edge (idle→active level): CPHA=0 samples miso; CPHA=1 shifts out the next bit.
    - Trailing edge: the opposite action.
  - SHIFT→DONE: after 2*DATA_W edges. sclk is back at CPOL.
  - DONE: lasts 1 cycle. RXD←shift register, done=1, busy=0, then →IDLE.
- Between transfers, sclk idles at CR.CPOL. A CPOL change while busy takes effect only after the transfer.
- Busy-time writes:
  - start while busy is ignored.
  - A TXD write while busy updates the register only; the in-flight byte is unaffected.
  - A CLKDIV/CPHA write while busy updates the register only; the next transfer uses it.
- Simultaneous events: completion and an RXD read or SR W1C in the same cycle leave done=1 (set wins). The RXD read in that cycle returns the previous RXD.
- Transfer duration: start-write edge to busy=0 is 2*DATA_W*(CLKDIV+1)+1 cycles.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Register offset localparams CR_OFS=3'd0, SR_OFS=3'd1, TXD_OFS=3'd2, RXD_OFS=3'd3, DIV_OFS=3'd4.
  - CR bit-index constants.
- Sub-module spi_master_core: holds the FSM, divider, edge counter and shift register, with start/busy/done handshake.
- The top holds the APB slave register file and read mux.

Test Plan:
1. Reset: assert PRESET 3 cycles → PREADY=0, cs_n=1, sclk=0, mosi=0. Reading SR→0x0, RXD→0x0, offset 0x1C→0x0.
2. APB timing: write CLKDIV=3 → PREADY high exactly 1 cycle, the cycle after PENABLE. Read back 0x3.
3. Mode 0 loopback (miso=mosi), CLKDIV=1, TXD=0xA5, CR=0x9:
   - 16 sclk edges, each 2 cycles apart; cs_n=0.
   - busy falls 33 cycles after the start edge; SR=0x2, RXD=0xA5.
   - Reading RXD then SR→0x0.
4. Mode 3 (CPOL=1, CPHA=1) against a slave model returning 0x3C, TXD=0xC3, CLKDIV=0:
   - Model captures 0xC3; RXD=0x3C.
   - sclk idles high before and after; mosi changes only on falling edges.
5. Start while busy: issue a second CR start and TXD=0xFF mid-transfer → the first transfer completes unchanged with one done. A following transfer sends 0xFF.
6. Simultaneous/reset:
   - SR W1C in the completion cycle → done remains 1.
   - PRESET at edge 7 of a transfer → sclk=CPOL reset value 0, busy=0, done=0, RXD=0.
